// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of independent down-counting timers sharing one tick prescaler
module timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int CLK_HZ   = 27000000,
    parameter int TICK_HZ  = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(CHANNELS)-1:0] sel,
    input  logic [WIDTH-1:0]            load_value,
    input  logic                        periodic,
    input  logic                        start,
    input  logic                        stop,
    input  logic [CHANNELS-1:0]         irq_enable,
    input  logic [CHANNELS-1:0]         clear,
    output logic [CHANNELS-1:0]         running,
    output logic [CHANNELS-1:0]         done,
    output logic [CHANNELS-1:0]         pending,
    output logic                        interrupt,
    output logic [WIDTH-1:0]            count
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int SW  = $clog2(CHANNELS);

    typedef enum logic {IDLE, RUN} state_t;

    logic [PW-1:0]     prescaler;
    logic              tick;
    state_t            state     [CHANNELS];
    state_t            state_n   [CHANNELS];
    logic [WIDTH-1:0]  counter   [CHANNELS];
    logic [WIDTH-1:0]  counter_n [CHANNELS];
    logic [WIDTH-1:0]  reload    [CHANNELS];
    logic [WIDTH-1:0]  reload_n  [CHANNELS];
    logic [CHANNELS-1:0] mode, mode_n, done_n, pending_n, pend_set;

    // Free-running prescaler; its phase is deliberately independent of start.
    assign tick = (prescaler == PW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Priority per channel: start > stop > tick expiry/decrement.
    always_comb begin
        mode_n   = mode;
        done_n   = done;
        pend_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_n[i]   = state[i];
            counter_n[i] = counter[i];
            reload_n[i]  = reload[i];
            if (start && (sel == SW'(i))) begin
                counter_n[i] = load_value;
                reload_n[i]  = load_value;
                mode_n[i]    = periodic;
                if (load_value == '0) begin
                    state_n[i]  = IDLE;
                    done_n[i]   = 1'b1;
                    pend_set[i] = 1'b1;
                end else begin
                    state_n[i] = RUN;
                    done_n[i]  = 1'b0;
                end
            end else if (stop && (sel == SW'(i))) begin
                state_n[i] = IDLE;
            end else if (tick && (state[i] == RUN)) begin
                if (counter[i] > WIDTH'(1)) begin
                    counter_n[i] = counter[i] - WIDTH'(1);
                end else begin
                    done_n[i]   = 1'b1;
                    pend_set[i] = 1'b1;
                    if (mode[i]) begin
                        counter_n[i] = reload[i];
                    end else begin
                        counter_n[i] = '0;
                        state_n[i]   = IDLE;
                    end
                end
            end
        end
        pending_n = pend_set | (pending & ~clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]   <= IDLE;
                counter[i] <= '0;
                reload[i]  <= '0;
            end
            mode    <= '0;
            done    <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]   <= state_n[i];
                counter[i] <= counter_n[i];
                reload[i]  <= reload_n[i];
            end
            mode    <= mode_n;
            done    <= done_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            running[i] = (state[i] == RUN);
        end
    end

    assign interrupt = |(pending & irq_enable);
    assign count     = (int'(sel) < CHANNELS) ? counter[sel] : '0;
endmodule
